// File: rtl/sister_vec_lane_alu.sv
// sister_vec_lane_alu: lane-serial packed-vector ALU.
// Two packed vectors of LANES x LANE_W bits are accepted together. One lane is
// processed per cycle in one of four modes (wrap/saturating add/sub). The
// block returns the packed result, per-lane overflow flags and a horizontal
// sum. Valid/ready handshakes are used on both the operand and result sides.
module sister_vec_lane_alu #(
  parameter int  LANES  = 3,
  parameter int  LANE_W = 8,
  localparam int RED_W  = LANE_W + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              mode,
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] sum,
  output logic [LANES-1:0]        ovf,
  output logic [RED_W-1:0]        red
);

  localparam int IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [LANES*LANE_W-1:0] a_q;
  logic [LANES*LANE_W-1:0] b_q;
  logic [1:0]              mode_q;
  logic [LANE_W-1:0]       a_i;
  logic [LANE_W-1:0]       b_i;
  logic [LANE_W:0]         add_x;
  logic [LANE_W:0]         sub_x;
  logic [LANE_W-1:0]       r;
  logic                    ovf_lane;
  logic                    accept;
  logic                    last_lane;

  // Handshake flags decode directly from the registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last_lane = (idx == IDX_W'(LANES - 1));

  // Current lane operands, extended by one bit so carry and borrow are explicit.
  assign a_i   = a_q[idx*LANE_W +: LANE_W];
  assign b_i   = b_q[idx*LANE_W +: LANE_W];
  assign add_x = {1'b0, a_i} + {1'b0, b_i};
  assign sub_x = {1'b0, a_i} - {1'b0, b_i};

  // State register; reset dominates everything else.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: defaults are assigned first so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_lane) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-lane result and flag for the selected mode.
  always_comb begin
    r        = add_x[LANE_W-1:0];
    ovf_lane = add_x[LANE_W];
    unique case (mode_q)
      2'b00: begin
        r        = add_x[LANE_W-1:0];
        ovf_lane = add_x[LANE_W];
      end
      2'b01: begin
        r        = add_x[LANE_W] ? {LANE_W{1'b1}} : add_x[LANE_W-1:0];
        ovf_lane = add_x[LANE_W];
      end
      2'b10: begin
        r        = sub_x[LANE_W-1:0];
        ovf_lane = sub_x[LANE_W];
      end
      default: begin
        r        = sub_x[LANE_W] ? '0 : sub_x[LANE_W-1:0];
        ovf_lane = sub_x[LANE_W];
      end
    endcase
  end

  // Operand capture on accept; later changes on a, b or mode are not seen.
  // NOTE: operand holding registers are not reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
    end
  end

  // Result accumulation: clear on accept, write one lane per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      sum <= '0;
      ovf <= '0;
      red <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            idx <= '0;
            sum <= '0;
            ovf <= '0;
            red <= '0;
          end
        end
        CALC: begin
          sum[idx*LANE_W +: LANE_W] <= r;
          ovf[idx]                  <= ovf_lane;
          red                       <= red + RED_W'(r);
          if (!last_lane) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sister_vec_lane_alu.sv
// Bench for sister_vec_lane_alu: a transaction-level model of the 3x8 instance
// checked every cycle, directed vectors with literal expectations, and a
// second 4x16 instance for the parameter sweep.
module tb_sister_vec_lane_alu;

  localparam int L0 = 3;
  localparam int W0 = 8;
  localparam int R0 = W0 + $clog2(L0);
  localparam int L1 = 4;
  localparam int W1 = 16;
  localparam int R1 = W1 + $clog2(L1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [1:0]        mode = '0;
  logic [L0*W0-1:0]  a = '0, b = '0, sum;
  logic [L0-1:0]     ovf;
  logic [R0-1:0]     red;

  logic              in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [1:0]        mode1 = '0;
  logic [L1*W1-1:0]  a1 = '0, b1 = '0, sum1;
  logic [L1-1:0]     ovf1;
  logic [R1-1:0]     red1;

  sister_vec_lane_alu #(.LANES(L0), .LANE_W(W0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .red(red)
  );

  sister_vec_lane_alu #(.LANES(L1), .LANE_W(W1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .mode(mode1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .ovf(ovf1), .red(red1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [L0*W0-1:0] sum;
    logic [L0-1:0]    ovf;
    logic [R0-1:0]    red;
  } res_t;

  // Whole-vector result from the arithmetic definition of each mode.
  function automatic res_t model(input logic [L0*W0-1:0] x, input logic [L0*W0-1:0] y,
                                 input logic [1:0] m);
    res_t res;
    int   mx;
    int   total;
    mx    = (1 << W0) - 1;
    total = 0;
    res   = '0;
    for (int i = 0; i < L0; i++) begin
      int ai, bi, rv;
      bit o;
      ai = int'(x[i*W0 +: W0]);
      bi = int'(y[i*W0 +: W0]);
      case (m)
        2'd0:    begin rv = (ai + bi) % (mx + 1);         o = (ai + bi) > mx; end
        2'd1:    begin rv = (ai + bi > mx) ? mx : ai + bi; o = (ai + bi) > mx; end
        2'd2:    begin rv = (ai - bi + mx + 1) % (mx + 1); o = ai < bi;        end
        default: begin rv = (ai < bi) ? 0 : ai - bi;       o = ai < bi;        end
      endcase
      res.sum[i*W0 +: W0] = W0'(rv);
      res.ovf[i]          = o;
      total += rv;
    end
    res.red = R0'(total);
    return res;
  endfunction

  // Transaction model: one outstanding op, result due L0 edges after accept.
  int   cyc = 0;
  bit   m_busy = 1'b0;
  bit   m_init = 1'b0;
  bit   m_rst_last = 1'b0;
  int   m_acc = 0;
  res_t m_exp = '0;

  always @(posedge clk) begin
    cyc++;
    m_rst_last = rst;
    if (rst) begin
      m_busy = 1'b0;
      m_init = 1'b1;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_exp  = model(a, b, mode);
      end
    end else if (cyc >= m_acc + L0 + 1 && out_ready) begin
      m_busy = 1'b0;
    end
  end

  // Per-cycle comparison of u0 against the model.
  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready", in_ready, !m_busy);
      check("out_valid", out_valid, m_busy && cyc >= m_acc + L0);
      if (m_busy && cyc >= m_acc + L0) begin
        check("sum", sum, m_exp.sum);
        check("ovf", ovf, m_exp.ovf);
        check("red", red, m_exp.red);
      end
      if (m_rst_last) begin
        check("rst_sum", sum, 0);
        check("rst_ovf", ovf, 0);
        check("rst_red", red, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    if (!out_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  // One op on u0 with out_ready high and literal expectations.
  task automatic run_op(input string tag, input logic [23:0] va, input logic [23:0] vb,
                        input logic [1:0] vm, input logic [23:0] es, input logic [2:0] eo,
                        input logic [9:0] er);
    int n;
    step();
    a = va; b = vb; mode = vm; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(tag, n);
    check({tag, "_latency"}, n, L0 + 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_red"}, red, er);
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    int   n, c0, c1;
    logic [23:0] hs;
    logic [2:0]  ho;
    logic [9:0]  hr;

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    run_op("wrap_add", 24'h82786E, 24'h645A50, 2'b00, 24'hE6D2BE, 3'b000, 10'h276);
    run_op("sat_add",  24'hF010FF, 24'h201001, 2'b01, 24'hFF20FF, 3'b101, 10'h21E);
    run_op("wrap_add2",24'hF010FF, 24'h201001, 2'b00, 24'h102000, 3'b101, 10'h030);
    run_op("sat_sub",  24'h055010, 24'h102010, 2'b11, 24'h003000, 3'b100, 10'h030);
    run_op("wrap_sub", 24'h055010, 24'h102010, 2'b10, 24'hF53000, 3'b100, 10'h125);

    // Backpressure with in_valid held and operands changing after accept.
    out_ready = 1'b0;
    step();
    a = 24'hF010FF; b = 24'h201001; mode = 2'b01; in_valid = 1'b1;
    step();
    a = 24'h123456; b = 24'h654321;
    wait_valid("bp", n);
    check("bp_sum", sum, 24'hFF20FF);
    check("bp_ovf", ovf, 3'b101);
    check("bp_red", red, 10'h21E);
    hs = sum; ho = ovf; hr = red;
    repeat (6) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", sum, hs);
      check("bp_hold_ovf", ovf, ho);
      check("bp_hold_red", red, hr);
      check("bp_hold_ready", in_ready, 0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_before_hs", out_valid, 1);
    @(negedge clk);
    check("bp_valid_after_hs", out_valid, 0);
    check("bp_ready_after_hs", in_ready, 1);
    @(negedge clk);
    check("bp_second_accept", in_ready, 0);
    step();
    in_valid = 1'b0;
    wait_valid("bp2", n);
    @(negedge clk);

    // Reset in the middle of a wrap add.
    step();
    a = 24'h82786E; b = 24'h645A50; mode = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_red", red, 0);
    check("mid_rst_ready", in_ready, 1);
    repeat (10) begin
      @(negedge clk);
      check("mid_rst_no_valid", out_valid, 0);
    end

    // Back-to-back on u0: accepts LANES+2 cycles apart.
    step();
    a = 24'h010203; b = 24'h0A0B0C; mode = 2'b00; in_valid = 1'b1;
    c0 = -1; c1 = -1;
    for (int i = 0; i < 30 && c1 < 0; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (c0 < 0) c0 = cyc;
        else        c1 = cyc;
      end
    end
    check("b2b_spacing", c1 - c0, L0 + 2);
    step();
    in_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Parameter sweep on u1 (4 x 16): saturating add clamps every lane.
    step();
    a1 = 64'hFFFF_FFFF_FFFF_FFFF; b1 = 64'h0001_0001_0001_0001; mode1 = 2'b01;
    in_valid1 = 1'b1;
    c0 = -1; c1 = -1; n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready1) begin
        if (c0 < 0)      c0 = cyc;
        else if (c1 < 0) c1 = cyc;
      end
      if (out_valid1) begin
        n++;
        check("p4_sum", sum1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("p4_ovf", ovf1, 4'hF);
        check("p4_red", red1, 18'h3FFFC);
      end
    end
    check("p4_b2b_spacing", c1 - c0, L1 + 2);
    check("p4_results_seen", n >= 2, 1);
    step();
    in_valid1 = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
